// File: rtl/tick_period_checker.sv
// Measures the clock-cycle interval between rising edges of tick_in and checks it
// against CONST +/- TOL, with lock tracking and a sticky timeout when no edge arrives.
module tick_period_checker #(
    parameter int CONST  = 10,
    parameter int WIDTH  = 8,
    parameter int TOL    = 0,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             mismatch,
    output logic             timeout,
    output logic             locked
);

    localparam int MCW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [WIDTH:0]   CONST_X = (WIDTH + 1)'(CONST);
    localparam logic [WIDTH:0]   TOL_X   = (WIDTH + 1)'(TOL);
    localparam logic [MCW-1:0]   LOCK_X  = MCW'(LOCK_N);
    // cnt_q holds interval-1, so the all-ones interval is reached at this count.
    localparam logic [WIDTH-1:0] TMO_CNT = {{(WIDTH - 1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state_q, state_d;
    logic             tick_prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             mismatch_q, mismatch_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;
    logic [MCW-1:0]   match_cnt_q, match_cnt_d;

    logic             tick_evt;
    logic             timeout_hit;
    logic             is_match;
    logic [WIDTH:0]   interval;
    logic [MCW-1:0]   match_inc;

    // Unsigned distance from CONST in WIDTH+1 bits; no wrap for any measurable interval.
    function automatic logic in_tolerance(input logic [WIDTH:0] ival);
        logic [WIDTH:0] diff;
        diff = (ival >= CONST_X) ? (ival - CONST_X) : (CONST_X - ival);
        return (diff <= TOL_X);
    endfunction

    function automatic logic [MCW-1:0] sat_inc(input logic [MCW-1:0] v);
        return (v >= LOCK_X) ? LOCK_X : (v + MCW'(1));
    endfunction

    // Stage 0: edge detection and interval evaluation
    always_comb begin
        tick_evt    = tick_in & ~tick_prev_q;
        interval    = {1'b0, cnt_q} + (WIDTH + 1)'(1);
        timeout_hit = (state_q == MEASURE) && (cnt_q == TMO_CNT);
        is_match    = in_tolerance(interval);
        match_inc   = sat_inc(match_cnt_q);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        mismatch_d     = 1'b0;
        timeout_d      = timeout_q;
        locked_d       = locked_q;
        match_cnt_d    = match_cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tick_evt) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (timeout_hit) begin
                    // A coincident edge loses to the timeout but still becomes the new reference.
                    timeout_d   = 1'b1;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = tick_evt ? MEASURE : IDLE;
                end else if (tick_evt) begin
                    period_d       = interval[WIDTH-1:0];
                    period_valid_d = 1'b1;
                    timeout_d      = 1'b0;
                    cnt_d          = '0;
                    if (is_match) begin
                        match_cnt_d = match_inc;
                        locked_d    = (match_inc == LOCK_X);
                    end else begin
                        mismatch_d  = 1'b1;
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_prev_q    <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= 1'b0;
            match_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            tick_prev_q    <= tick_in;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            mismatch_q     <= mismatch_d;
            timeout_q      <= timeout_d;
            locked_q       <= locked_d;
            match_cnt_q    <= match_cnt_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign mismatch     = mismatch_q;
    assign timeout      = timeout_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_tick_period_checker.sv
// Directed bench for tick_period_checker: table of tick intervals with expected
// outputs, plus hand sequences for timeout, reset and tolerance corners.
module tb_tick_period_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       tick2 = 1'b0;
    logic [7:0] period, t_period;
    logic       pv, mm, to, lk;
    logic       t_pv, t_mm, t_to, t_lk;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tick_period_checker dut (
        .clk(clk), .rst(rst), .tick_in(tick),
        .period(period), .period_valid(pv), .mismatch(mm),
        .timeout(to), .locked(lk)
    );

    tick_period_checker #(.CONST(10), .WIDTH(8), .TOL(1), .LOCK_N(4)) dut_tol (
        .clk(clk), .rst(rst), .tick_in(tick2),
        .period(t_period), .period_valid(t_pv), .mismatch(t_mm),
        .timeout(t_to), .locked(t_lk)
    );

    typedef struct {
        int   lo;
        int   hi;
        logic pv;
        int   per;
        logic mm;
        logic lk;
        logic to;
    } rec_t;

    rec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rec(input int idx);
        rec_t r;
        logic quiet;
        r = tbl[idx];
        quiet = 1'b1;
        tick = 1'b0;
        repeat (r.lo) begin
            cyc();
            if (pv) quiet = 1'b0;
        end
        tick = 1'b1;
        cyc();
        chk($sformatf("rec%0d_pv", idx), int'(pv), int'(r.pv));
        chk($sformatf("rec%0d_period", idx), int'(period), r.per);
        chk($sformatf("rec%0d_mismatch", idx), int'(mm), int'(r.mm));
        chk($sformatf("rec%0d_locked", idx), int'(lk), int'(r.lk));
        chk($sformatf("rec%0d_timeout", idx), int'(to), int'(r.to));
        repeat (r.hi - 1) begin
            cyc();
            if (pv) quiet = 1'b0;
        end
        chk($sformatf("rec%0d_quiet", idx), int'(quiet), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic quiet;

        tbl[0]  = '{3, 1, 1'b0, 0,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{9, 1, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{11, 1, 1'b1, 12, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{9, 1, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{9, 5, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{5, 5, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{5, 5, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{5, 1, 1'b1, 10, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{3, 1, 1'b0, 10, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{9, 1, 1'b1, 10, 1'b0, 1'b0, 1'b0};

        repeat (3) cyc();
        chk("reset_period", int'(period), 0);
        chk("reset_flags", int'({pv, mm, to, lk}), 0);
        rst = 1'b0;

        for (int i = 0; i <= 13; i++) run_rec(i);

        // Timeout with no edge: sets on the 255th cycle after the last event.
        tick = 1'b0;
        quiet = 1'b1;
        repeat (254) begin
            cyc();
            if (pv || to) quiet = 1'b0;
        end
        chk("tmo_not_early", int'(quiet), 1);
        cyc();
        chk("tmo_set", int'(to), 1);
        chk("tmo_locked_clr", int'(lk), 0);
        chk("tmo_no_pv", int'(pv), 0);

        for (int i = 14; i <= 15; i++) run_rec(i);

        // Edge coincident with timeout becomes the reference edge.
        tick = 1'b0;
        repeat (254) cyc();
        tick = 1'b1;
        cyc();
        chk("tmo_coinc_set", int'(to), 1);
        chk("tmo_coinc_pv", int'(pv), 0);
        tick = 1'b0;
        repeat (9) cyc();
        tick = 1'b1;
        cyc();
        chk("tmo_coinc_next_pv", int'(pv), 1);
        chk("tmo_coinc_next_period", int'(period), 10);
        chk("tmo_coinc_next_to", int'(to), 0);

        // Asynchronous reset mid-interval, released with tick_in high.
        tick = 1'b0;
        repeat (5) cyc();
        rst = 1'b1;
        tick = 1'b1;
        #2;
        chk("rst_async_period", int'(period), 0);
        chk("rst_async_flags", int'({pv, mm, to, lk}), 0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_first_evt_pv", int'(pv), 0);
        tick = 1'b0;
        repeat (9) cyc();
        tick = 1'b1;
        cyc();
        chk("rst_second_evt_pv", int'(pv), 1);
        chk("rst_second_evt_period", int'(period), 10);
        tick = 1'b0;

        // Tolerance instance: intervals 9, 11, 12 against 10 +/- 1.
        repeat (2) cyc();
        tick2 = 1'b1;
        cyc();
        chk("tol_ref_pv", int'(t_pv), 0);
        tick2 = 1'b0;
        repeat (8) cyc();
        tick2 = 1'b1;
        cyc();
        chk("tol9_pv", int'(t_pv), 1);
        chk("tol9_period", int'(t_period), 9);
        chk("tol9_mismatch", int'(t_mm), 0);
        tick2 = 1'b0;
        repeat (10) cyc();
        tick2 = 1'b1;
        cyc();
        chk("tol11_period", int'(t_period), 11);
        chk("tol11_mismatch", int'(t_mm), 0);
        tick2 = 1'b0;
        repeat (11) cyc();
        tick2 = 1'b1;
        cyc();
        chk("tol12_period", int'(t_period), 12);
        chk("tol12_mismatch", int'(t_mm), 1);
        tick2 = 1'b0;
        cyc();
        chk("tol12_mm_oneshot", int'(t_mm), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_checker.md
TICK_PERIOD_CHECKER -- requirements
Module: tick_period_checker

Interface
REQ-001 Parameter CONST, default 10: expected interval, in clk cycles, between consecutive tick rising edges.
REQ-002 Parameter WIDTH, default 8: width of the interval counter and of the period output.
REQ-003 Parameter TOL, default 0: allowed absolute deviation from CONST that still counts as a match.
REQ-004 Parameter LOCK_N, default 4: number of consecutive matching intervals required to assert locked.
REQ-005 The block SHALL use one clock, clk; reset is asynchronous and active-high, named rst.
REQ-006 clk  input  1  rising-edge system clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 tick_in  input  1  synchronous tick/pulse train to be measured; pulse width arbitrary.
REQ-009 period  output  WIDTH  last measured interval in clk cycles.
REQ-010 period_valid  output  1  one-cycle strobe, period updated.
REQ-011 mismatch  output  1  one-cycle strobe coincident with period_valid when the interval is outside CONST±TOL.
REQ-012 timeout  output  1  sticky flag, no edge within 2^WIDTH−1 cycles.
REQ-013 locked  output  1  LOCK_N consecutive matching intervals observed.

Function
REQ-014 Edge event at clock edge n SHALL occur iff tick_in is sampled 1 at edge n and 0 at edge n−1 (registered previous sample); a held-high tick_in produces one event.
REQ-015 Interval SHALL equal the number of clk edges between two consecutive edge events (events at edges n and n+10 give 10).
REQ-016 The FSM SHALL have states IDLE (no reference edge) and MEASURE (reference edge held, counting).
REQ-017 IDLE: on an edge event, the FSM SHALL enter MEASURE with the count initialised so the next event yields the correct interval; no period_valid.
REQ-018 MEASURE: on an edge event, period SHALL load the interval, period_valid SHALL pulse for exactly one cycle, and counting SHALL restart; the FSM stays in MEASURE.
REQ-019 Outputs SHALL be registered and updated at the same clock edge that detects the event (latency: one cycle after tick_in rises).
REQ-020 Match means |interval − CONST| ≤ TOL; the comparison SHALL be done in WIDTH+1 bits without wrap.
REQ-021 On a non-match valid interval: mismatch SHALL pulse, the match counter SHALL clear, and locked SHALL deassert at that edge.
REQ-022 On a match: the match counter SHALL increment, saturating at LOCK_N; locked SHALL assert at the edge where the counter reaches LOCK_N.
REQ-023 In MEASURE, when the interval reaches 2^WIDTH−1 with no event: timeout SHALL set, the match counter and locked SHALL clear, and the FSM SHALL go to IDLE.
REQ-024 An edge event on the timeout edge SHALL lose to the timeout; it becomes the reference edge (enter MEASURE), with no period_valid.
REQ-025 timeout SHALL remain set until the next period_valid, and clears at that edge.
REQ-026 period SHALL hold its value between period_valid strobes.

Reset
REQ-027 While rst=1: period=0, period_valid=0, mismatch=0, timeout=0, locked=0, FSM=IDLE, counters=0, and the previous tick_in sample=0; all take effect immediately, without a clock.
REQ-028 Reset asserted mid-interval SHALL discard the partial measurement; the first edge event after release SHALL produce no period_valid.
REQ-029 If tick_in is high when rst releases, the first clk edge SHALL count as an edge event (previous sample=0).

Verification
REQ-030 Ticks every 10 cycles, default parameters -> 1st event no strobe; each later event gives period=10, period_valid=1 for 1 cycle, mismatch=0; locked=1 at the 4th strobe.
REQ-031 After lock, one interval of 12 -> period=12, mismatch=1, locked=0 at the same edge; four further 10-cycle intervals re-assert locked.
REQ-032 Event, then 255 cycles with no tick (WIDTH=8) -> timeout=1 and locked=0 at cycle 255; next event gives no strobe; the following 10-cycle interval gives period=10 and clears timeout.
REQ-033 tick_in held high for 5 cycles every 10 cycles -> one event per pulse, period=10.
REQ-034 rst pulsed 5 cycles into an interval -> all outputs 0 immediately; first post-reset event gives no strobe; second gives the correct period.
REQ-035 TOL=1, intervals 9, 11, 12 -> mismatch = 0, 0, 1 respectively.
